sort_stream_engine: RTL and testbench

//  Parametrised successor to our single-shot sorter. Accepts up to DEPTH words of WIDTH bits
//  on a valid/ready stream, sorts them with an odd-even transposition network in

---
 rtl/sort_pkg.sv | 24 ++
 rtl/sort_cmp_swap.sv | 24 ++
 rtl/sort_stream_engine.sv | 178 +++++++++++++++++
 tb/tb_sort_stream_engine.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sort_pkg                                                                   |
// | Shared types and sizing helpers for the streaming sort engine.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int sort_cycles(input int depth, input int stages);
    return (depth + stages - 1) / stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_cmp_swap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sort_cmp_swap                                                              |
// | Compare-exchange cell; swaps only on strict inequality to keep stability.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sort_cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_desc,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic w_swap;

  assign w_swap = i_desc ? (i_a < i_b) : (i_a > i_b);
  assign o_lo   = w_swap ? i_b : i_a;
  assign o_hi   = w_swap ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/sort_stream_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sort_stream_engine                                                         |
// | Frame-based stream sorter: load, odd-even transposition sort, drain.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sort_stream_engine
  import sort_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 15,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             sort_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int   C_CW       = cnt_w(DEPTH);
  localparam int   C_SORT_CYC = sort_cycles(DEPTH, STAGES);
  localparam int   C_HALF     = DEPTH / 2;
  localparam int   C_ODD      = (DEPTH - 1) / 2;
  localparam logic C_PAR_STEP = 1'(STAGES % 2);

  state_t                       r_state, w_next;
  logic [DEPTH-1:0][WIDTH-1:0]  r_slot;
  logic [C_CW-1:0]              r_count, r_rd, r_cyc;
  logic                         r_dir, r_par, r_in_en;
  logic                         w_in_xfer, w_out_xfer, w_frame_end, w_dir_eff;
  logic [WIDTH-1:0]             w_pad, w_rd_data;
  logic [DEPTH-1:0][WIDTH-1:0]  w_sorted;

  assign w_in_xfer   = in_valid & in_ready;
  assign w_out_xfer  = out_valid & out_ready;
  assign w_frame_end = w_in_xfer & (in_last | (r_count == C_CW'(DEPTH - 1)));
  // A one-beat frame has not latched its direction yet when padding is chosen.
  assign w_dir_eff   = (r_count == '0) ? sort_desc : r_dir;
  assign w_pad       = w_dir_eff ? '0 : '1;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_rd == C_CW'(i)) w_rd_data = r_slot[i];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic                        w_par;
    logic [DEPTH-1:0][WIDTH-1:0] w_in, w_out;
    logic [C_HALF-1:0][WIDTH-1:0] w_a, w_b, w_lo, w_hi;

    if (s == 0) begin : g_first
      assign w_in = r_slot;
    end else begin : g_chain
      assign w_in = g_stage[s-1].w_out;
    end

    assign w_par = r_par ^ 1'(s % 2);

    for (genvar j = 0; j < C_HALF; j++) begin : g_pair
      if (2 * j + 2 < DEPTH) begin : g_both
        assign w_a[j] = w_par ? w_in[2*j+1] : w_in[2*j];
        assign w_b[j] = w_par ? w_in[2*j+2] : w_in[2*j+1];
      end else begin : g_even_only
        assign w_a[j] = w_in[2*j];
        assign w_b[j] = w_in[2*j+1];
      end
      sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
        .i_a   (w_a[j]),
        .i_b   (w_b[j]),
        .i_desc(r_dir),
        .o_lo  (w_lo[j]),
        .o_hi  (w_hi[j])
      );
    end

    always_comb begin
      w_out = w_in;
      for (int j = 0; j < C_HALF; j++) begin
        if (!w_par) begin
          w_out[2*j]   = w_lo[j];
          w_out[2*j+1] = w_hi[j];
        end
      end
      for (int j = 0; j < C_ODD; j++) begin
        if (w_par) begin
          w_out[2*j+1] = w_lo[j];
          w_out[2*j+2] = w_hi[j];
        end
      end
    end
  end

  assign w_sorted = g_stage[STAGES-1].w_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= LOAD;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_frame_end) w_next = SORT;
      SORT:    if (r_cyc == C_CW'(C_SORT_CYC - 1)) w_next = DRAIN;
      DRAIN:   if (w_out_xfer && out_last) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (r_state)
      LOAD:  in_ready = r_in_en;
      SORT:  busy = 1'b1;
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = w_rd_data;
        out_last  = (r_rd == r_count - C_CW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot  <= '0;
      r_count <= '0;
      r_rd    <= '0;
      r_cyc   <= '0;
      r_dir   <= 1'b0;
      r_par   <= 1'b0;
      r_in_en <= 1'b0;
    end else begin
      r_in_en <= 1'b1;
      case (r_state)
        LOAD: if (w_in_xfer) begin
          r_count <= r_count + C_CW'(1);
          if (r_count == '0) r_dir <= sort_desc;
          // The closing beat also pads the unused tail so it sorts to the end.
          for (int i = 0; i < DEPTH; i++) begin
            if (r_count == C_CW'(i))                        r_slot[i] <= in_data;
            else if (w_frame_end && (r_count < C_CW'(i)))   r_slot[i] <= w_pad;
          end
          r_cyc <= '0;
          r_par <= 1'b0;
        end
        SORT: begin
          r_slot <= w_sorted;
          r_cyc  <= r_cyc + C_CW'(1);
          r_par  <= r_par ^ C_PAR_STEP;
          r_rd   <= '0;
        end
        DRAIN: if (w_out_xfer) begin
          r_rd <= r_rd + C_CW'(1);
          if (out_last) r_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_stream_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sort_stream_engine                                                      |
// | Scoreboard bench driving three engine instances (STAGES 1, 3, 15).         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sort_stream_engine;

  localparam int W  = 8;
  localparam int D  = 15;
  localparam int NU = 3;

  typedef logic [W-1:0] q8_t[$];

  logic         clk;
  logic         rst_n;
  logic         in_valid  [NU];
  logic         in_ready  [NU];
  logic [W-1:0] in_data   [NU];
  logic         in_last   [NU];
  logic         sort_desc [NU];
  logic         out_valid [NU];
  logic         out_ready [NU];
  logic [W-1:0] out_data  [NU];
  logic         out_last  [NU];
  logic         busy      [NU];

  int           n_checks = 0;
  int           n_err    = 0;
  int           cyc      = 0;
  int           last_in_cyc = 0;
  logic [W-1:0] sb[$];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    sort_stream_engine #(
      .WIDTH (W),
      .DEPTH (D),
      .STAGES((g == 0) ? 1 : ((g == 1) ? 3 : 15))
    ) u_dut (
      .clk      (clk),
      .reset_n  (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_last  (in_last[g]),
      .sort_desc(sort_desc[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .out_last (out_last[g]),
      .busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sort_cyc(input int u);
    return (u == 0) ? 15 : ((u == 1) ? 5 : 1);
  endfunction

  function automatic q8_t model_sort(input q8_t d, input bit desc);
    q8_t r = d;
    logic [W-1:0] t;
    for (int i = 1; i < r.size(); i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (r[j] > r[j-1]) : (r[j] < r[j-1])) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
      end
    end
    return r;
  endfunction

  task automatic send_frame(input int u, input q8_t d, input bit desc, input int gap_pct,
                            input bit toggle, input bit hold);
    q8_t s;
    int  guard;
    s = model_sort(d, desc);
    foreach (s[i]) sb.push_back(s[i]);
    for (int k = 0; k < d.size(); k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid[u] = 1'b0;
        @(negedge clk);
      end
      in_valid[u]  = 1'b1;
      in_data[u]   = d[k];
      in_last[u]   = (k == d.size() - 1);
      sort_desc[u] = (toggle && k > 0) ? ~desc : desc;
      guard = 0;
      while (!in_ready[u] && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready[u]) begin
        n_checks++; n_err++;
        $display("FAIL in_ready_timeout u%0d beat %0d: in_ready=%b, required 1", u, k, in_ready[u]);
        break;
      end
      @(negedge clk);
    end
    last_in_cyc = cyc;
    if (hold) begin
      in_valid[u] = 1'b1;
      in_data[u]  = 8'h5A;
      in_last[u]  = 1'b0;
      guard = 0;
      while (busy[u] && guard < 2000) begin
        n_checks++;
        if (in_ready[u] !== 1'b0) begin
          n_err++;
          $display("FAIL hold_in_ready u%0d: in_ready=%b, required 0", u, in_ready[u]);
        end
        @(negedge clk);
        guard++;
      end
    end
    in_valid[u] = 1'b0;
    in_last[u]  = 1'b0;
  endtask

  task automatic recv_frame(input int u, input int n, input int rdy_pct, input bit chk_lat,
                            input int lat_exp);
    int           got = 0;
    int           guard = 0;
    bit           stall = 1'b0;
    logic [W-1:0] hd = '0;
    logic         hl = 1'b0;
    logic [W-1:0] e;
    while (got < n) begin
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if (out_valid[u] !== 1'b1 || out_data[u] !== hd || out_last[u] !== hl) begin
          n_err++;
          $display("FAIL stall_hold u%0d: valid=%b data=%h last=%b, required 1 %h %b",
                   u, out_valid[u], out_data[u], out_last[u], hd, hl);
        end
      end
      out_ready[u] = ($urandom_range(99) < rdy_pct);
      if (out_valid[u] && out_ready[u]) begin
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_checks++;
        if (out_data[u] !== e) begin
          n_err++;
          $display("FAIL out_data u%0d beat %0d: got %h, required %h", u, got, out_data[u], e);
        end
        n_checks++;
        if (out_last[u] !== (got == n - 1)) begin
          n_err++;
          $display("FAIL out_last u%0d beat %0d: got %b, required %b", u, got, out_last[u], got == n - 1);
        end
        if (got == 0 && chk_lat) begin
          n_checks++;
          if (cyc + 1 - last_in_cyc !== lat_exp) begin
            n_err++;
            $display("FAIL latency u%0d: got %0d clocks, required %0d", u, cyc + 1 - last_in_cyc, lat_exp);
          end
        end
        got++;
        stall = 1'b0;
      end else begin
        stall = out_valid[u];
        hd    = out_data[u];
        hl    = out_last[u];
      end
      guard++;
      if (guard > 3000) begin
        n_checks++; n_err++;
        $display("FAIL recv_timeout u%0d: got %0d beats, required %0d", u, got, n);
        break;
      end
    end
    @(negedge clk);
    out_ready[u] = 1'b0;
    n_checks++;
    if (out_valid[u] !== 1'b0 || busy[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
      n_err++;
      $display("FAIL frame_end u%0d: valid=%b busy=%b in_ready=%b, required 0 0 1",
               u, out_valid[u], busy[u], in_ready[u]);
    end
  endtask

  task automatic check_idle_zero(input string name, input int u, input logic exp_rdy);
    n_checks++;
    if (in_ready[u] !== exp_rdy || out_valid[u] !== 1'b0 || out_last[u] !== 1'b0 ||
        busy[u] !== 1'b0 || out_data[u] !== 8'h00) begin
      n_err++;
      $display("FAIL %s u%0d: rdy=%b valid=%b last=%b busy=%b data=%h, required %b 0 0 0 00",
               name, u, in_ready[u], out_valid[u], out_last[u], busy[u], out_data[u], exp_rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) check_idle_zero("reset_state", u, 1'b0);
    rst_n = 1'b1;
    #1;
    check_idle_zero("release_cycle", 0, 1'b0);
    @(negedge clk);
    for (int u = 0; u < NU; u++) check_idle_zero("after_release", u, 1'b1);
  endtask

  task automatic test_full_frame();
    q8_t d;
    for (int u = 0; u < NU; u++) begin
      d = {};
      for (int k = 15; k >= 1; k--) d.push_back(8'(k));
      fork
        send_frame(u, d, 1'b0, 0, 1'b0, 1'b0);
        recv_frame(u, 15, 100, 1'b1, sort_cyc(u) + 1);
      join
    end
  endtask

  task automatic test_partial_desc();
    q8_t d = '{8'd3, 8'd200, 8'd7, 8'd7, 8'd0};
    fork
      send_frame(0, d, 1'b1, 0, 1'b0, 1'b0);
      recv_frame(0, 5, 100, 1'b1, 16);
    join
  endtask

  task automatic test_partial_pad();
    q8_t d = '{8'hFF, 8'h01, 8'hFF};
    fork
      send_frame(1, d, 1'b0, 0, 1'b0, 1'b0);
      recv_frame(1, 3, 100, 1'b1, 6);
    join
  endtask

  task automatic test_ignore_mid_frame();
    q8_t d1 = '{8'd5, 8'd1, 8'd9, 8'd3};
    q8_t d2 = '{8'd4, 8'd40, 8'd2};
    q8_t d3 = '{8'd2, 8'd8};
    fork
      send_frame(0, d1, 1'b0, 0, 1'b1, 1'b1);
      recv_frame(0, 4, 100, 1'b0, 0);
    join
    fork
      send_frame(1, d2, 1'b1, 0, 1'b1, 1'b1);
      recv_frame(1, 3, 60, 1'b0, 0);
    join
    fork
      send_frame(0, d3, 1'b0, 0, 1'b0, 1'b0);
      recv_frame(0, 2, 100, 1'b0, 0);
    join
  endtask

  task automatic test_reset_mid_frame();
    q8_t d = {};
    q8_t d2 = '{8'h90, 8'h80, 8'hA0};
    q8_t d3 = '{8'h07, 8'h03, 8'h05, 8'h01};
    int  guard;
    for (int k = 0; k < D; k++) d.push_back(8'(8'h80 + k));
    send_frame(0, d, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_sort_busy: busy=%b, required 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_mid_sort", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    send_frame(0, d2, 1'b0, 0, 1'b0, 1'b0);
    guard = 0;
    while (!out_valid[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h80) begin
      n_err++;
      $display("FAIL mid_drain_reach: valid=%b data=%h, required 1 80", out_valid[0], out_data[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_mid_drain", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    fork
      send_frame(0, d3, 1'b0, 0, 1'b0, 1'b0);
      recv_frame(0, 4, 100, 1'b1, 16);
    join
  endtask

  task automatic test_random();
    q8_t d;
    int  u, n;
    bit  desc;
    for (int f = 0; f < 200; f++) begin
      u    = f % NU;
      n    = $urandom_range(1, D);
      desc = 1'($urandom_range(0, 1));
      d    = {};
      for (int k = 0; k < n; k++)
        d.push_back((f % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
      fork
        send_frame(u, d, desc, 30, 1'b0, 1'b0);
        recv_frame(u, n, 50, 1'b0, 0);
      join
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < NU; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      in_last[u]   = 1'b0;
      sort_desc[u] = 1'b0;
      out_ready[u] = 1'b0;
    end
    test_reset();
    test_full_frame();
    test_partial_desc();
    test_partial_pad();
    test_ignore_mid_frame();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
